// File: rtl/l2_cache_control.sv
// l2_cache_control: control FSM for a 4-way set-associative L2 cache.
// Sequences the tag/data/valid/dirty arrays and the PLRU array through the
// hit, clean-miss and dirty-miss flows between the L1 miss port and physical
// memory, and keeps saturating hit/miss performance counters.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mem_read, mem_write        L1 request (held until mem_resp)
//   mem_resp                   one-cycle completion pulse to L1
//   way_hit/valid/dirty        per-way status of the indexed set (datapath)
//   lru_victim                 PLRU-selected way for the indexed set
//   way_sel                    way addressed by the datapath muxes
//   data_load, tag_load        per-way array write enables
//   valid_load, dirty_load     write valid/dirty of way_sel; dirty_in = value
//   lru_load                   update PLRU bits using way_sel
//   addr_sel, data_in_sel      pmem address mux / data array input mux
//   pmem_read, pmem_write      memory requests (held until pmem_resp)
//   pmem_resp                  one-cycle memory completion
//   cnt_clr                    synchronous clear of both counters
//   hit_count, miss_count      saturating performance counters
//   multi_hit_err              sticky multiple-way-hit flag
//
// The control outputs are decoded from the current state and the datapath
// status in the same cycle; the arrays capture them on the next rising edge.
module l2_cache_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  input  logic [3:0]       way_hit,
  input  logic [3:0]       way_valid,
  input  logic [3:0]       way_dirty,
  input  logic [1:0]       lru_victim,
  output logic [1:0]       way_sel,
  output logic [3:0]       data_load,
  output logic [3:0]       tag_load,
  output logic             valid_load,
  output logic             dirty_load,
  output logic             dirty_in,
  output logic             lru_load,
  output logic             addr_sel,
  output logic             data_in_sel,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic             multi_hit_err
);

  localparam int unsigned WAYS = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHECK     = 2'd1,
    WRITEBACK = 2'd2,
    FILL      = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] victim_q;
  logic       refill_q;

  logic       req_c;
  logic       hit_c;
  logic       multi_c;
  logic [1:0] hit_way_c;
  logic [1:0] victim_c;
  logic       victim_dirty_c;

  assign req_c   = mem_read | mem_write;
  assign hit_c   = |way_hit;
  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi_c = |(way_hit & 4'(way_hit - 4'd1));

  // Encode the hit way; scanning downward lets the lowest index win.
  always_comb begin
    hit_way_c = 2'd0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (way_hit[i]) hit_way_c = 2'(i);
    end
  end

  // Victim: lowest invalid way, else the PLRU choice.
  always_comb begin
    victim_c = lru_victim;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!way_valid[i]) victim_c = 2'(i);
    end
  end

  assign victim_dirty_c = way_valid[victim_c] & way_dirty[victim_c];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (req_c) state_d = CHECK;
      CHECK: begin
        if (hit_c)               state_d = IDLE;
        else if (victim_dirty_c) state_d = WRITEBACK;
        else                     state_d = FILL;
      end
      WRITEBACK: if (pmem_resp) state_d = FILL;
      FILL:      if (pmem_resp) state_d = CHECK;
      default:   state_d = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    mem_resp    = 1'b0;
    way_sel     = 2'd0;
    data_load   = 4'd0;
    tag_load    = 4'd0;
    valid_load  = 1'b0;
    dirty_load  = 1'b0;
    dirty_in    = 1'b0;
    lru_load    = 1'b0;
    addr_sel    = 1'b0;
    data_in_sel = 1'b0;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    unique case (state_q)
      IDLE: ;
      CHECK: begin
        if (hit_c) begin
          way_sel  = hit_way_c;
          lru_load = 1'b1;
          mem_resp = 1'b1;
          // Write hit (or write after refill): merge L1 data and mark dirty.
          if (mem_write) begin
            data_load  = 4'b0001 << hit_way_c;
            dirty_load = 1'b1;
            dirty_in   = 1'b1;
          end
        end
      end
      WRITEBACK: begin
        pmem_write = 1'b1;
        addr_sel   = 1'b1;
        way_sel    = victim_q;
      end
      FILL: begin
        pmem_read = 1'b1;
        way_sel   = victim_q;
        // Install the line as clean; the write merge happens in the re-lookup.
        if (pmem_resp) begin
          data_load   = 4'b0001 << victim_q;
          tag_load    = 4'b0001 << victim_q;
          data_in_sel = 1'b1;
          valid_load  = 1'b1;
          dirty_load  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Victim latch and refill flag (suppresses hit counting on the re-lookup).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      victim_q <= 2'd0;
      refill_q <= 1'b0;
    end else begin
      if (state_q == CHECK && !hit_c) victim_q <= victim_c;
      if (state_q == FILL && pmem_resp)  refill_q <= 1'b1;
      else if (state_q == CHECK && hit_c) refill_q <= 1'b0;
    end
  end

  // Saturating performance counters; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (cnt_clr) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state_q == CHECK) begin
      if (hit_c && !refill_q && hit_count != {CNT_W{1'b1}})
        hit_count <= hit_count + CNT_W'(1);
      if (!hit_c && miss_count != {CNT_W{1'b1}})
        miss_count <= miss_count + CNT_W'(1);
    end
  end

  // Sticky multiple-hit error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          multi_hit_err <= 1'b0;
    else if (state_q == CHECK && multi_c) multi_hit_err <= 1'b1;
  end

endmodule
